// File: rtl/jt49_env_gen.sv
// jt49_env_gen: JT49 PSG envelope generator.
// A period counter produces envelope steps at the programmed rate; a 32-step
// shape sequencer turns those steps into a 5-bit logarithmic envelope level.
// Optional build macro: JT49_EG_16STEP_EN selects AY-3-8910 style 16-step
// ramps (counter advances by 2, LSB of the output replicates the MSB).
module jt49_env_gen #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [PW-1:0] period,
  input  logic [3:0]    shape,
  input  logic          restart,
  output logic [4:0]    env,
  output logic          stopped
);

`ifdef JT49_EG_16STEP_EN
  localparam logic [4:0] CNT_INC  = 5'd2;
  localparam logic [4:0] CNT_LAST = 5'd30;
`else
  localparam logic [4:0] CNT_INC  = 5'd1;
  localparam logic [4:0] CNT_LAST = 5'd31;
`endif

  // shape bit positions
  localparam int CONT = 3;
  localparam int ATT  = 2;
  localparam int ALT  = 1;
  localparam int HOLD = 0;

  logic [PW-1:0] pcnt_q,    pcnt_d;
  logic [4:0]    cnt_q,     cnt_d;
  logic          att_q,     att_d;
  logic          stopped_q, stopped_d;
  logic [4:0]    env_q,     env_d;

  logic [PW:0]   pcnt_inc;
  logic [PW:0]   per_eff;
  logic          step_hit;

  // Ramp position to output level: attack counts up, decay is the inverse.
  function automatic logic [4:0] env_map(input logic [4:0] c, input logic a);
    logic [4:0] level;
    level = a ? c : ~c;
`ifdef JT49_EG_16STEP_EN
    env_map = {level[4:1], level[4]};
`else
    env_map = level;
`endif
  endfunction

  // Period compare in PW+1 bits so an all-ones period never wraps; 0 acts as 1.
  always_comb begin
    pcnt_inc = {1'b0, pcnt_q} + {{PW{1'b0}}, 1'b1};
    per_eff  = (period == '0) ? {{PW{1'b0}}, 1'b1} : {1'b0, period};
    step_hit = (pcnt_inc >= per_eff);
  end

  // Next-state logic: restart beats everything, otherwise advance on cen.
  always_comb begin
    pcnt_d    = pcnt_q;
    cnt_d     = cnt_q;
    att_d     = att_q;
    stopped_d = stopped_q;
    env_d     = env_q;
    if (restart) begin
      pcnt_d    = '0;
      cnt_d     = '0;
      att_d     = shape[ATT];
      stopped_d = 1'b0;
      env_d     = env_map(5'd0, shape[ATT]);
    end else if (cen) begin
      pcnt_d = step_hit ? '0 : pcnt_q + {{(PW-1){1'b0}}, 1'b1};
      // A frozen sequencer ignores steps; its held env stays in env_q.
      if (step_hit && !stopped_q) begin
        if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + CNT_INC;
          env_d = env_map(cnt_d, att_q);
        end else if (!shape[CONT]) begin
          // one-shot shapes always end silent
          stopped_d = 1'b1;
          env_d     = 5'd0;
        end else if (shape[HOLD]) begin
          stopped_d = 1'b1;
          env_d     = env_map(cnt_q, att_q) ^ {5{shape[ALT]}};
        end else begin
          cnt_d = 5'd0;
          att_d = att_q ^ shape[ALT];
          env_d = env_map(5'd0, att_d);
        end
      end
    end
  end

  // State registers; reset leaves the generator silent and frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q    <= '0;
      cnt_q     <= '0;
      att_q     <= 1'b0;
      stopped_q <= 1'b1;
      env_q     <= '0;
    end else begin
      pcnt_q    <= pcnt_d;
      cnt_q     <= cnt_d;
      att_q     <= att_d;
      stopped_q <= stopped_d;
      env_q     <= env_d;
    end
  end

  assign env     = env_q;
  assign stopped = stopped_q;

endmodule

// File: tb/tb_jt49_env_gen.sv
// tb_jt49_env_gen: directed self-checking bench for jt49_env_gen.
// Table of per-clock vectors for short mixed sequences, then loop-driven
// sequences for full ramps, holds, repeats, period 0 and asynchronous reset.
module tb_jt49_env_gen;

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic [15:0] period;
  logic [3:0]  shape;
  logic        restart;
  logic [4:0]  env;
  logic        stopped;

  int checks = 0;
  int errors = 0;

  jt49_env_gen #(.PW(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .period  (period),
    .shape   (shape),
    .restart (restart),
    .env     (env),
    .stopped (stopped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rs;
    logic        ce;
    logic [15:0] per;
    logic [3:0]  sh;
    logic [4:0]  ee;
    logic        es;
  } vec_t;

  vec_t tbl[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [4:0] ee, input logic es);
    checks++;
    if (env !== ee || stopped !== es) begin
      errors++;
      $display("FAIL %s: env=%0d stopped=%0b, expected env=%0d stopped=%0b",
               nm, env, stopped, ee, es);
    end
  endtask

  task automatic do_restart(input logic [3:0] sh, input logic [15:0] per,
                            input logic [4:0] ee);
    shape   = sh;
    period  = per;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart", ee, 1'b0);
  endtask

  initial begin
    int         s;
    int         n;
    int         ph;
    logic [4:0] e;
    logic [4:0] lvl;

    rst_n   = 1'b0;
    cen     = 1'b0;
    period  = 16'd1;
    shape   = 4'h0;
    restart = 1'b0;
    #12;
    chk("reset_state", 5'd0, 1'b1);
    tick();
    rst_n = 1'b1;
    cen   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_before_restart", 5'd0, 1'b1);
    end

`ifndef JT49_EG_16STEP_EN
    // per-clock vectors: cen gating, period change, restart on step edge, period 0
    tbl[0]  = '{1'b1, 1'b0, 16'd3, 4'hD, 5'd0,  1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'd3, 4'hD, 5'd0,  1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'd3, 4'hD, 5'd0,  1'b0};
    tbl[3]  = '{1'b0, 1'b1, 16'd3, 4'hD, 5'd0,  1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'd3, 4'hD, 5'd1,  1'b0};
    tbl[5]  = '{1'b0, 1'b1, 16'd3, 4'hD, 5'd1,  1'b0};
    tbl[6]  = '{1'b0, 1'b1, 16'd1, 4'hD, 5'd2,  1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'd1, 4'hD, 5'd3,  1'b0};
    tbl[8]  = '{1'b1, 1'b1, 16'd1, 4'h4, 5'd0,  1'b0};
    tbl[9]  = '{1'b0, 1'b1, 16'd1, 4'h4, 5'd1,  1'b0};
    tbl[10] = '{1'b1, 1'b1, 16'd1, 4'h0, 5'd31, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 16'd1, 4'h0, 5'd30, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'd1, 4'h0, 5'd30, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 16'd0, 4'h0, 5'd29, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 16'd4, 4'h0, 5'd29, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 16'd4, 4'h0, 5'd29, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 16'd4, 4'h0, 5'd29, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 16'd4, 4'h0, 5'd28, 1'b0};
    for (int i = 0; i < 18; i++) begin
      restart = tbl[i].rs;
      cen     = tbl[i].ce;
      period  = tbl[i].per;
      shape   = tbl[i].sh;
      tick();
      chk($sformatf("vec%0d", i), tbl[i].ee, tbl[i].es);
    end
    restart = 1'b0;

    // 0xD: attack then hold at max; live shape change must not disturb the hold
    cen = 1'b1;
    do_restart(4'hD, 16'd1, 5'd0);
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk("attack_hold_ramp", 5'(k), 1'b0);
    end
    tick();
    chk("attack_hold_end", 5'd31, 1'b1);
    shape = 4'h0;
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("attack_hold_held", 5'd31, 1'b1);
    end

    // 0x8: repeating decay saw, period 2
    do_restart(4'h8, 16'd2, 5'd31);
    for (int c = 1; c <= 70; c++) begin
      tick();
      s = c / 2;
      chk("saw_decay", 5'(31 - (s % 32)), 1'b0);
    end

    // 0xA: triangle starting with decay, extremes shown twice
    do_restart(4'hA, 16'd1, 5'd31);
    for (int k = 1; k <= 130; k++) begin
      tick();
      ph = k % 64;
      e  = (ph < 32) ? 5'(31 - ph) : 5'(ph - 32);
      chk("triangle", e, 1'b0);
    end

    // 0xB: decay then hold at max (alternate of final level)
    do_restart(4'hB, 16'd1, 5'd31);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k <= 31) chk("decay_althold", 5'(31 - k), 1'b0);
      else         chk("decay_althold_held", 5'd31, 1'b1);
    end

    // 0x0: one-shot decay then silent
    do_restart(4'h0, 16'd1, 5'd31);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k <= 31) chk("oneshot_decay", 5'(31 - k), 1'b0);
      else         chk("oneshot_decay_held", 5'd0, 1'b1);
    end

    // period 0 and period 1 with cen every third clock give the same trace
    for (int pv = 0; pv < 2; pv++) begin
      cen = 1'b0;
      do_restart(4'hD, 16'(pv), 5'd0);
      for (int c = 1; c <= 100; c++) begin
        cen = (c % 3 == 0);
        tick();
        n = c / 3;
        chk($sformatf("sparse_cen_p%0d", pv), (n <= 31) ? 5'(n) : 5'd31, (n >= 32));
      end
    end

    // asynchronous reset mid-ramp at env=17
    cen = 1'b1;
    do_restart(4'hD, 16'd1, 5'd0);
    for (int k = 0; k < 17; k++) tick();
    chk("before_async_reset", 5'd17, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_immediate", 5'd0, 1'b1);
    tick();
    chk("async_reset_held", 5'd0, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("after_reset_frozen", 5'd0, 1'b1);
    end
`else
    // 16-step attack then hold, LSB replicates MSB
    cen = 1'b1;
    do_restart(4'hD, 16'd1, 5'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k <= 15) begin
        lvl = 5'(2 * k);
        chk("attack16", {lvl[4:1], lvl[4]}, 1'b0);
      end else begin
        chk("attack16_held", 5'd31, 1'b1);
      end
    end

    // 16-step one-shot decay
    do_restart(4'h0, 16'd1, 5'd31);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k <= 15) begin
        lvl = 5'(31 - 2 * k);
        chk("decay16", {lvl[4:1], lvl[4]}, 1'b0);
      end else begin
        chk("decay16_held", 5'd0, 1'b1);
      end
    end

    // asynchronous reset mid-ramp
    do_restart(4'hD, 16'd1, 5'd0);
    for (int k = 0; k < 5; k++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset16", 5'd0, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("after_reset16_frozen", 5'd0, 1'b1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
